pong_engine: RTL and testbench
==============================

PONG_ENGINE -- requirements
Module: pong_engine

Interface
REQ-001 Parameter FIELD_W, 640, playfield width in pixels.
REQ-002 Parameter FIELD_H, 480, playfield height in pixels.
REQ-003 Parameter WALL, 8, border thickness in pixels.
REQ-004 Parameter BALL, 16, ball edge length in pixels.
REQ-005 Parameter PAD_LEN, 112, paddle length in pixels; paddle thickness is fixed at 8.
REQ-006 Parameter BOOST_MAX, 31, paddle step saturation value.
REQ-007 Parameter BOOST_DIV, 8, ticks per boost increment.
REQ-008 Parameter SERVE_TICKS, 60, ball hold time in SERVE.
REQ-009 Parameter SCORE_W, 4, score counter width.
REQ-010 Parameter WIN_SCORE, 9, two-player winning score.
REQ-011 Parameter MODE, 0; 0 = single player with bottom paddle and top wall, 1 = two players with bottom paddle p0 and top paddle p1.
REQ-012 Port CLOCK_50 input 1, the only clock; all state changes on its rising edge.
REQ-013 Port RESET input 1, reset is asynchronous and active-high.
REQ-014 Port tick input 1, single-cycle frame advance strobe.
REQ-015 Port btn_start input 1, active-high level.
REQ-016 Port btn_left input 2, per-player move-left request, active-high.
REQ-017 Port btn_right input 2, per-player move-right request, active-high.
REQ-018 Port ball_x output clog2(FIELD_W) bits, ball left column; ball_y output clog2(FIELD_H) bits, ball top row.
REQ-019 Port pad0_x, pad1_x outputs clog2(FIELD_W) bits, paddle left columns.
REQ-020 Port score0, score1 outputs SCORE_W bits; state output 3 bits; over output 1, one-cycle pulse.

Function
REQ-021 State encoding is IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4; all updates occur only in cycles with tick=1, and outputs change on the edge that samples tick (latency 1); with tick=0 everything holds.
REQ-022 Centre positions are ball (FIELD_W/2-BALL/2, FIELD_H/2-BALL/2) and paddle (FIELD_W-PAD_LEN)/2; the bottom paddle top row is FIELD_H-16, and the top paddle occupies rows WALL..WALL+7.
REQ-023 IDLE: ball and paddles are centred; btn_start=1 moves to SERVE and clears both scores.
REQ-024 SERVE: ball is held at centre for SERVE_TICKS ticks, then moves to PLAY; dx is +1 and dy is +1 (down) unless set by the last miss.
REQ-025 PLAY: on each tick, paddles move, then the ball moves by dx, dy (one pixel per axis); collisions are evaluated on pre-move positions.
REQ-026 Boost, per player: increments every BOOST_DIV ticks while exactly one of that player's buttons is held; saturates at BOOST_MAX; returns to 1 when neither or both buttons are held.
REQ-027 Paddle move: position changes by ±boost, clamped to [WALL, FIELD_W-WALL-PAD_LEN]; there is no wrap-around.
REQ-028 Side walls: ball_x<=WALL forces dx=+1; ball_x+BALL>=FIELD_W-WALL forces dx=-1.
REQ-029 Top, MODE 0: ball_y<=WALL forces dy=+1.
REQ-030 Paddle hit requires the ball moving toward the paddle, the ball reaching the paddle row, and ball_x+BALL>pad_x and ball_x<pad_x+PAD_LEN; on a hit, dy is reversed, and if that paddle moved this tick, dx takes the paddle's direction.
REQ-031 MODE 0: each paddle hit increments score0, saturating at all-ones.
REQ-032 A miss occurs when ball_y>FIELD_H-BALL, or in MODE 1 when ball_y==0 while moving up; a miss moves the FSM to MISS.
REQ-033 MISS, MODE 0: the FSM moves to OVER.
REQ-034 MISS, MODE 1: the opponent score increments; the FSM moves to OVER if that score now equals WIN_SCORE, otherwise to SERVE with dy pointing toward the player who missed.
REQ-035 over pulses for exactly one cycle on entry to OVER.
REQ-036 OVER: positions and scores hold; btn_start=1 moves to IDLE.
REQ-037 Corner case: side and top/bottom reflections in the same tick both apply.
REQ-038 Paddle hit and miss in the same tick: the hit wins.
REQ-039 MODE 0: pad1_x is held at centre and score1 at 0; the p1 buttons are ignored.

Reset
REQ-040 While RESET=1, regardless of clock or tick: state=IDLE, ball at centre, both paddles at centre, scores 0, boosts 1, dx=+1, dy=+1, serve counter 0, over=0.
REQ-041 Deasserting RESET mid-game resumes from IDLE at the first subsequent tick.

Verification
REQ-042 Reset: assert RESET asynchronously during PLAY -> same cycle: state=0, ball (312,232), pads 264, scores 0.
REQ-043 Serve: btn_start=1 on a tick -> state=1; after 60 ticks state=2; next tick ball (313,233).
REQ-044 Boost: hold btn_right[0] for 24 ticks -> per-tick step 1 then 2 then 3; pad0_x saturates at 520 and never exceeds it.
REQ-045 Wall: ball at x=616 with dx=+1 -> next tick x=615, dx=-1.
REQ-046 MODE 0 miss: hold btn_left[0] until pad0_x=8, let the ball fall past y=464 -> state=3 then 4; over high for exactly one cycle; score0 equals the number of hits.
REQ-047 MODE 1: p0 misses 9 serves -> score1 increments 1..9, state=4 after the ninth miss; score0=0.

Source files
------------

// File: rtl/pong_engine.sv
// Pong game engine: ball motion, paddle control with boost, scoring and
// game-state sequencing. Every update is gated by the one-cycle frame tick.
module pong_engine #(
  parameter int FIELD_W     = 640,
  parameter int FIELD_H     = 480,
  parameter int WALL        = 8,
  parameter int BALL        = 16,
  parameter int PAD_LEN     = 112,
  parameter int BOOST_MAX   = 31,
  parameter int BOOST_DIV   = 8,
  parameter int SERVE_TICKS = 60,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9,
  parameter int MODE        = 0
) (
  input  logic                       CLOCK_50,
  input  logic                       RESET,
  input  logic                       tick,
  input  logic                       btn_start,
  input  logic [1:0]                 btn_left,
  input  logic [1:0]                 btn_right,
  output logic [$clog2(FIELD_W)-1:0] ball_x,
  output logic [$clog2(FIELD_H)-1:0] ball_y,
  output logic [$clog2(FIELD_W)-1:0] pad0_x,
  output logic [$clog2(FIELD_W)-1:0] pad1_x,
  output logic [SCORE_W-1:0]         score0,
  output logic [SCORE_W-1:0]         score1,
  output logic [2:0]                 state,
  output logic                       over
);

  localparam int XW = $clog2(FIELD_W);
  localparam int YW = $clog2(FIELD_H);
  localparam int CW = ((XW > YW) ? XW : YW) + 2;
  localparam int BW = $clog2(BOOST_MAX + 1);
  localparam int DW = $clog2(BOOST_DIV + 1);
  localparam int SW = $clog2(SERVE_TICKS + 1);
  localparam logic TWO_P = (MODE == 1);

  localparam logic [XW-1:0] BALL_X0 = XW'(FIELD_W / 2 - BALL / 2);
  localparam logic [YW-1:0] BALL_Y0 = YW'(FIELD_H / 2 - BALL / 2);
  localparam logic [XW-1:0] PAD_X0  = XW'((FIELD_W - PAD_LEN) / 2);
  localparam logic [XW-1:0] PAD_MIN = XW'(WALL);
  localparam logic [XW-1:0] PAD_MAX = XW'(FIELD_W - WALL - PAD_LEN);
  localparam logic [XW-1:0] ONE_X   = XW'(1);
  localparam logic [YW-1:0] ONE_Y   = YW'(1);

  localparam logic [CW-1:0] C_WALL    = CW'(WALL);
  localparam logic [CW-1:0] C_BALL    = CW'(BALL);
  localparam logic [CW-1:0] C_RIGHT   = CW'(FIELD_W - WALL);
  localparam logic [CW-1:0] C_PAD_LEN = CW'(PAD_LEN);
  localparam logic [CW-1:0] C_BOT_ROW = CW'(FIELD_H - 16);
  localparam logic [CW-1:0] C_TOP_ROW = CW'(WALL + 8);
  localparam logic [CW-1:0] C_MISS_Y  = CW'(FIELD_H - BALL);

  localparam logic [BW-1:0]      BOOST_ONE  = BW'(1);
  localparam logic [BW-1:0]      BOOST_TOP  = BW'(BOOST_MAX);
  localparam logic [DW-1:0]      DIV_LAST   = DW'(BOOST_DIV - 1);
  localparam logic [DW-1:0]      DIV_ONE    = DW'(1);
  localparam logic [SW-1:0]      SERVE_LAST = SW'(SERVE_TICKS - 1);
  localparam logic [SW-1:0]      SERVE_ONE  = SW'(1);
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_WIN  = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_MISS  = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t                 fsm;
  logic [1:0][XW-1:0]     pad;
  logic [1:0][BW-1:0]     boost;
  logic [1:0][DW-1:0]     div_cnt;
  logic                   dx_neg;
  logic                   dy_up;
  logic [SW-1:0]          serve_cnt;
  logic                   miss_top;

  logic [1:0]             one_btn;
  logic [1:0]             pad_moved;
  logic [1:0][XW-1:0]     pad_nx;
  logic [1:0][BW-1:0]     boost_nx;
  logic [1:0][DW-1:0]     div_nx;

  logic [CW-1:0]          bx_e;
  logic [CW-1:0]          by_e;
  logic [CW-1:0]          p0_e;
  logic [CW-1:0]          p1_e;
  logic                   hit0;
  logic                   hit1;
  logic                   miss_p1;
  logic                   miss_now;
  logic                   ndx_neg;
  logic                   ndy_up;
  logic [XW-1:0]          ball_x_nx;
  logic [YW-1:0]          ball_y_nx;
  logic [SCORE_W-1:0]     score0_inc;
  logic [SCORE_W-1:0]     score1_inc;

  assign pad0_x = pad[0];
  assign pad1_x = pad[1];
  assign state  = fsm;

  // Next paddle position and boost for each player; the second player only
  // responds in two-player mode, otherwise its paddle stays parked.
  always_comb begin
    one_btn   = '0;
    pad_moved = '0;
    pad_nx    = pad;
    boost_nx  = boost;
    div_nx    = div_cnt;
    for (int p = 0; p < 2; p++) begin
      one_btn[p] = ((p == 0) || TWO_P) && (btn_left[p] ^ btn_right[p]);
      if (one_btn[p] && btn_right[p]) begin
        if (pad[p] >= PAD_MAX - XW'(boost[p]))
          pad_nx[p] = PAD_MAX;
        else
          pad_nx[p] = pad[p] + XW'(boost[p]);
      end else if (one_btn[p]) begin
        if (pad[p] <= PAD_MIN + XW'(boost[p]))
          pad_nx[p] = PAD_MIN;
        else
          pad_nx[p] = pad[p] - XW'(boost[p]);
      end
      pad_moved[p] = (pad_nx[p] != pad[p]);
      if (one_btn[p]) begin
        if (div_cnt[p] == DIV_LAST) begin
          div_nx[p] = '0;
          if (boost[p] != BOOST_TOP)
            boost_nx[p] = boost[p] + BOOST_ONE;
        end else begin
          div_nx[p] = div_cnt[p] + DIV_ONE;
        end
      end else begin
        boost_nx[p] = BOOST_ONE;
        div_nx[p]   = '0;
      end
    end
  end

  // Ball collision and miss detection on the positions before this tick's
  // moves; walls are applied last so a paddle deflection cannot push the ball
  // out through a side wall.
  always_comb begin
    bx_e     = CW'(ball_x);
    by_e     = CW'(ball_y);
    p0_e     = CW'(pad[0]);
    p1_e     = CW'(pad[1]);
    hit0     = !dy_up && (by_e + C_BALL >= C_BOT_ROW) &&
               (bx_e + C_BALL > p0_e) && (bx_e < p0_e + C_PAD_LEN);
    hit1     = TWO_P && dy_up && (by_e <= C_TOP_ROW) &&
               (bx_e + C_BALL > p1_e) && (bx_e < p1_e + C_PAD_LEN);
    miss_p1  = TWO_P && dy_up && (by_e == '0);
    miss_now = !(hit0 || hit1) && ((by_e > C_MISS_Y) || miss_p1);
    ndx_neg  = dx_neg;
    ndy_up   = dy_up;
    if (hit0) begin
      ndy_up = 1'b1;
      if (pad_moved[0])
        ndx_neg = btn_left[0];
    end
    if (hit1) begin
      ndy_up = 1'b0;
      if (pad_moved[1])
        ndx_neg = btn_left[1];
    end
    if (!TWO_P && (by_e <= C_WALL))
      ndy_up = 1'b0;
    if (bx_e <= C_WALL)
      ndx_neg = 1'b0;
    if (bx_e + C_BALL >= C_RIGHT)
      ndx_neg = 1'b1;
    ball_x_nx  = ndx_neg ? (ball_x - ONE_X) : (ball_x + ONE_X);
    ball_y_nx  = ndy_up ? (ball_y - ONE_Y) : (ball_y + ONE_Y);
    score0_inc = (score0 == '1) ? score0 : (score0 + SCORE_ONE);
    score1_inc = (score1 == '1) ? score1 : (score1 + SCORE_ONE);
  end

  // Game state machine; all state advances on tick, and over is a
  // single-clock pulse raised on the edge that enters OVER.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      fsm       <= S_IDLE;
      ball_x    <= BALL_X0;
      ball_y    <= BALL_Y0;
      pad[0]    <= PAD_X0;
      pad[1]    <= PAD_X0;
      boost     <= {2{BOOST_ONE}};
      div_cnt   <= '0;
      dx_neg    <= 1'b0;
      dy_up     <= 1'b0;
      serve_cnt <= '0;
      miss_top  <= 1'b0;
      score0    <= '0;
      score1    <= '0;
      over      <= 1'b0;
    end else begin
      over <= 1'b0;
      if (tick) begin
        case (fsm)
          S_IDLE: begin
            ball_x    <= BALL_X0;
            ball_y    <= BALL_Y0;
            pad[0]    <= PAD_X0;
            pad[1]    <= PAD_X0;
            boost     <= {2{BOOST_ONE}};
            div_cnt   <= '0;
            dx_neg    <= 1'b0;
            dy_up     <= 1'b0;
            serve_cnt <= '0;
            if (btn_start) begin
              fsm    <= S_SERVE;
              score0 <= '0;
              score1 <= '0;
            end
          end
          S_SERVE: begin
            ball_x <= BALL_X0;
            ball_y <= BALL_Y0;
            if (serve_cnt == SERVE_LAST) begin
              serve_cnt <= '0;
              fsm       <= S_PLAY;
            end else begin
              serve_cnt <= serve_cnt + SERVE_ONE;
            end
          end
          S_PLAY: begin
            pad     <= pad_nx;
            boost   <= boost_nx;
            div_cnt <= div_nx;
            if (miss_now) begin
              fsm      <= S_MISS;
              miss_top <= miss_p1;
            end else begin
              ball_x <= ball_x_nx;
              ball_y <= ball_y_nx;
              dx_neg <= ndx_neg;
              dy_up  <= ndy_up;
              if (!TWO_P && hit0)
                score0 <= score0_inc;
            end
          end
          S_MISS: begin
            if (!TWO_P) begin
              fsm  <= S_OVER;
              over <= 1'b1;
            end else begin
              if (miss_top)
                score0 <= score0_inc;
              else
                score1 <= score1_inc;
              if ((miss_top ? score0_inc : score1_inc) == SCORE_WIN) begin
                fsm  <= S_OVER;
                over <= 1'b1;
              end else begin
                fsm       <= S_SERVE;
                ball_x    <= BALL_X0;
                ball_y    <= BALL_Y0;
                boost     <= {2{BOOST_ONE}};
                div_cnt   <= '0;
                serve_cnt <= '0;
                dx_neg    <= 1'b0;
                dy_up     <= miss_top;
              end
            end
          end
          S_OVER: begin
            if (btn_start) begin
              fsm     <= S_IDLE;
              ball_x  <= BALL_X0;
              ball_y  <= BALL_Y0;
              pad[0]  <= PAD_X0;
              pad[1]  <= PAD_X0;
              boost   <= {2{BOOST_ONE}};
              div_cnt <= '0;
            end
          end
          default: fsm <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine: one single-player and one two-player
// instance, driven by hand-traced ball trajectories.
module tb_pong_engine;

  logic       CLOCK_50 = 1'b0;
  logic       RESET;
  logic       tick0, tick1;
  logic       start0, start1;
  logic [1:0] l0, r0, l1, r1;

  logic [9:0] u0_ball_x, u0_pad0_x, u0_pad1_x;
  logic [8:0] u0_ball_y;
  logic [3:0] u0_score0, u0_score1;
  logic [2:0] u0_state;
  logic       u0_over;

  logic [9:0] u1_ball_x, u1_pad0_x, u1_pad1_x;
  logic [8:0] u1_ball_y;
  logic [3:0] u1_score0, u1_score1;
  logic [2:0] u1_state;
  logic       u1_over;

  int checks = 0;
  int errors = 0;

  pong_engine #(.MODE(0)) u0 (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .tick     (tick0),
    .btn_start(start0),
    .btn_left (l0),
    .btn_right(r0),
    .ball_x   (u0_ball_x),
    .ball_y   (u0_ball_y),
    .pad0_x   (u0_pad0_x),
    .pad1_x   (u0_pad1_x),
    .score0   (u0_score0),
    .score1   (u0_score1),
    .state    (u0_state),
    .over     (u0_over)
  );

  pong_engine #(.MODE(1)) u1 (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .tick     (tick1),
    .btn_start(start1),
    .btn_left (l1),
    .btn_right(r1),
    .ball_x   (u1_ball_x),
    .ball_y   (u1_ball_y),
    .pad0_x   (u1_pad0_x),
    .pad1_x   (u1_pad1_x),
    .score0   (u1_score0),
    .score1   (u1_score1),
    .state    (u1_state),
    .over     (u1_over)
  );

  // Free-running 100 MHz-style clock
  always #5 CLOCK_50 = ~CLOCK_50;

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Issue n frame ticks to one instance; returns on the falling edge after
  // the last sampled tick so outputs are settled
  task automatic applyStimulus(input int dut, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_50);
      if (dut == 0) tick0 = 1'b1;
      else          tick1 = 1'b1;
      @(negedge CLOCK_50);
      tick0 = 1'b0;
      tick1 = 1'b0;
    end
  endtask

  // Directed sequence
  initial begin
    RESET = 1'b1; tick0 = 1'b0; tick1 = 1'b0; start0 = 1'b0; start1 = 1'b0;
    l0 = 2'b00; r0 = 2'b00; l1 = 2'b00; r1 = 2'b00;
    #12;
    checkOutput("rst_state", 32'(u0_state), 0);
    checkOutput("rst_ball_x", 32'(u0_ball_x), 312);
    checkOutput("rst_ball_y", 32'(u0_ball_y), 232);
    checkOutput("rst_pad0", 32'(u0_pad0_x), 264);
    checkOutput("rst_pad1", 32'(u0_pad1_x), 264);
    checkOutput("rst_score0", 32'(u0_score0), 0);
    checkOutput("rst_over", 32'(u0_over), 0);
    @(negedge CLOCK_50);
    RESET = 1'b0;

    // Single player: start is ignored without tick
    start0 = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    checkOutput("notick_state", 32'(u0_state), 0);
    applyStimulus(0, 1);
    checkOutput("serve_enter", 32'(u0_state), 1);
    start0 = 1'b0;
    applyStimulus(0, 59);
    checkOutput("serve_59", 32'(u0_state), 1);
    checkOutput("serve_hold_x", 32'(u0_ball_x), 312);
    applyStimulus(0, 1);
    checkOutput("serve_60", 32'(u0_state), 2);
    checkOutput("serve_hold_y", 32'(u0_ball_y), 232);

    // Boost: hold right for player 0 (player 1 buttons pressed but ignored)
    r0 = 2'b11;
    applyStimulus(0, 1);
    checkOutput("play1_ball_x", 32'(u0_ball_x), 313);
    checkOutput("play1_ball_y", 32'(u0_ball_y), 233);
    checkOutput("boost_t1", 32'(u0_pad0_x), 265);
    applyStimulus(0, 7);
    checkOutput("boost_t8", 32'(u0_pad0_x), 272);
    applyStimulus(0, 1);
    checkOutput("boost_t9", 32'(u0_pad0_x), 274);
    applyStimulus(0, 7);
    checkOutput("boost_t16", 32'(u0_pad0_x), 288);
    applyStimulus(0, 1);
    checkOutput("boost_t17", 32'(u0_pad0_x), 291);
    applyStimulus(0, 7);
    checkOutput("boost_t24", 32'(u0_pad0_x), 312);
    checkOutput("p1_ignored", 32'(u0_pad1_x), 264);
    applyStimulus(0, 35);
    checkOutput("boost_t59", 32'(u0_pad0_x), 512);
    applyStimulus(0, 1);
    checkOutput("boost_t60", 32'(u0_pad0_x), 520);
    applyStimulus(0, 4);
    checkOutput("boost_sat", 32'(u0_pad0_x), 520);
    r0 = 2'b00;

    // No tick: everything holds
    repeat (4) @(negedge CLOCK_50);
    checkOutput("hold_ball_x", 32'(u0_ball_x), 376);
    checkOutput("hold_ball_y", 32'(u0_ball_y), 296);

    // Ball reaches the paddle row over the parked paddle at 520
    applyStimulus(0, 152);
    checkOutput("pre_hit_x", 32'(u0_ball_x), 528);
    checkOutput("pre_hit_y", 32'(u0_ball_y), 448);
    applyStimulus(0, 1);
    checkOutput("hit_y", 32'(u0_ball_y), 447);
    checkOutput("hit_x", 32'(u0_ball_x), 529);
    checkOutput("hit_score0", 32'(u0_score0), 1);

    // Right wall while player 0 slides to the left limit
    applyStimulus(0, 83);
    l0 = 2'b01;
    applyStimulus(0, 4);
    checkOutput("wall_pre_x", 32'(u0_ball_x), 616);
    applyStimulus(0, 1);
    checkOutput("wall_x", 32'(u0_ball_x), 615);
    checkOutput("wall_y", 32'(u0_ball_y), 359);
    applyStimulus(0, 1);
    checkOutput("wall_next_x", 32'(u0_ball_x), 614);
    applyStimulus(0, 94);
    checkOutput("pad_left_lim", 32'(u0_pad0_x), 8);
    checkOutput("t400_ball_x", 32'(u0_ball_x), 520);
    l0 = 2'b00;

    // Top wall, then left wall
    applyStimulus(0, 257);
    checkOutput("top_wall_y", 32'(u0_ball_y), 9);
    checkOutput("top_wall_x", 32'(u0_ball_x), 263);
    applyStimulus(0, 256);
    checkOutput("left_wall_x", 32'(u0_ball_x), 9);

    // Ball falls past the paddle row: miss, then game over
    applyStimulus(0, 200);
    checkOutput("fall_state", 32'(u0_state), 2);
    checkOutput("fall_y", 32'(u0_ball_y), 465);
    applyStimulus(0, 1);
    checkOutput("miss_state", 32'(u0_state), 3);
    checkOutput("miss_hold_x", 32'(u0_ball_x), 209);
    applyStimulus(0, 1);
    checkOutput("over_state", 32'(u0_state), 4);
    checkOutput("over_pulse", 32'(u0_over), 1);
    @(negedge CLOCK_50);
    checkOutput("over_cleared", 32'(u0_over), 0);
    checkOutput("over_score0", 32'(u0_score0), 1);
    checkOutput("over_score1", 32'(u0_score1), 0);
    applyStimulus(0, 3);
    checkOutput("over_hold", 32'(u0_state), 4);
    checkOutput("over_hold_pad", 32'(u0_pad0_x), 8);
    start0 = 1'b1;
    applyStimulus(0, 1);
    checkOutput("over_to_idle", 32'(u0_state), 0);
    checkOutput("idle_pad0", 32'(u0_pad0_x), 264);
    applyStimulus(0, 1);
    checkOutput("restart_state", 32'(u0_state), 1);
    checkOutput("restart_score0", 32'(u0_score0), 0);
    start0 = 1'b0;

    // Two players: player 0 misses nine serves
    start1 = 1'b1;
    applyStimulus(1, 1);
    start1 = 1'b0;
    applyStimulus(1, 60);
    checkOutput("m1_first_play", 32'(u1_state), 2);
    for (int r = 1; r <= 9; r++) begin
      applyStimulus(1, 233);
      checkOutput("m1_play", 32'(u1_state), 2);
      applyStimulus(1, 1);
      checkOutput("m1_miss", 32'(u1_state), 3);
      applyStimulus(1, 1);
      checkOutput("m1_score1", 32'(u1_score1), r);
      checkOutput("m1_next_state", 32'(u1_state), (r == 9) ? 4 : 1);
      checkOutput("m1_over", 32'(u1_over), (r == 9) ? 1 : 0);
      if (r < 9) begin
        checkOutput("m1_recentre", 32'(u1_ball_x), 312);
        applyStimulus(1, 60);
      end
    end
    checkOutput("m1_score0", 32'(u1_score0), 0);

    // Asynchronous reset in the middle of play
    start1 = 1'b1;
    applyStimulus(1, 2);
    start1 = 1'b0;
    applyStimulus(1, 60);
    applyStimulus(1, 10);
    checkOutput("pre_rst_x", 32'(u1_ball_x), 322);
    #2 RESET = 1'b1;
    #1;
    checkOutput("async_state", 32'(u1_state), 0);
    checkOutput("async_ball_x", 32'(u1_ball_x), 312);
    checkOutput("async_ball_y", 32'(u1_ball_y), 232);
    checkOutput("async_pad0", 32'(u1_pad0_x), 264);
    checkOutput("async_pad1", 32'(u1_pad1_x), 264);
    checkOutput("async_score1", 32'(u1_score1), 0);
    checkOutput("async_u0_state", 32'(u0_state), 0);
    @(negedge CLOCK_50);
    RESET = 1'b0;
    applyStimulus(1, 1);
    checkOutput("resume_idle", 32'(u1_state), 0);
    start1 = 1'b1;
    applyStimulus(1, 1);
    checkOutput("resume_serve", 32'(u1_state), 1);
    start1 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
